fetch_mem_arbiter: RTL and testbench
====================================

Name: fetch_mem_arbiter

Overview:
- Shares the single physical-memory line port between the instruction-side cache (feeds fetch; read-only) and the data-side cache (read/write).
- Sits between both cache miss interfaces and the cacheline adaptor.
- Grants one requester per transaction, holds the grant until pmem_resp, then returns to idle.
- Ties are broken round-robin so neither fetch nor memory stages starve.

Parameters:
- LINE_W, 256, width of one cache line in bits.
- ADDR_W, 32, physical address width in bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (asserted when 0).
- i_read  in  1  I-side line read request, level, held until i_resp.
- i_addr  in  ADDR_W  I-side line address, stable while i_read is high.
- i_rdata  out  LINE_W  line data returned to the I-side.
- i_resp  out  1  I-side transaction complete, one-cycle pulse.
- d_read  in  1  D-side line read request, level.
- d_write  in  1  D-side line write-back request, level; never high together with d_read.
- d_addr  in  ADDR_W  D-side line address.
- d_wdata  in  LINE_W  D-side write line.
- d_rdata  out  LINE_W  line data returned to the D-side.
- d_resp  out  1  D-side transaction complete, one-cycle pulse.
- pmem_read  out  1  read command to the adaptor.
- pmem_write  out  1  write command to the adaptor.
- pmem_addr  out  ADDR_W  address to the adaptor.
- pmem_wdata  out  LINE_W  write data to the adaptor.
- pmem_rdata  in  LINE_W  read data from the adaptor.
- pmem_resp  in  1  adaptor done, one-cycle pulse.
- owner  out  2  status: 00 idle, 01 I-side, 10 D-side, 11 recover.

Behaviour:
- States: IDLE, SERVE_I, SERVE_D, RECOVER. The state register is the only sequential element besides last_grant (1 bit: 0 = I, 1 = D).
- Reset (rst == 0, asynchronous):
  - state = IDLE, last_grant = I (so the first tie goes to D).
  - Every output is 0 immediately, including mid-transaction; the in-flight adaptor transaction is abandoned.
- IDLE:
  - No request: stay in IDLE.
  - Only i_read: go to SERVE_I.
  - Only d_read or d_write: go to SERVE_D.
  - Both sides requesting: grant the side opposite last_grant.
  - last_grant is updated on entry to SERVE_x.
  - Decision is registered: request visible at edge N, pmem command high from cycle N+1. Minimum request-to-command latency is 1 cycle.
- SERVE_I:
  - pmem_read = 1, pmem_write = 0, pmem_addr = i_addr, pmem_wdata = 0.
  - i_rdata = pmem_rdata and i_resp = pmem_resp, both combinational passthrough.
  - On pmem_resp: go to RECOVER.
- SERVE_D:
  - pmem_read = d_read, pmem_write = d_write, pmem_addr = d_addr, pmem_wdata = d_wdata.
  - d_rdata = pmem_rdata and d_resp = pmem_resp.
  - On pmem_resp: go to RECOVER.
- RECOVER:
  - Exactly one cycle with all pmem commands 0, so the cache can drop its request after its resp.
  - Go to IDLE unconditionally.
  - Back-to-back transactions are therefore spaced by at least 2 command-free cycles (RECOVER plus IDLE).
- Outputs:
  - pmem_read and pmem_write are Moore outputs (depend on state and owner inputs only, never on the other side's request).
  - i_resp and d_resp are never high in the same cycle.
  - The non-owner's rdata is 0 and its resp is 0.
- Request withdrawn while being served (protocol violation): the grant is still held until pmem_resp. resp is still pulsed to the owner. No lockup.
- pmem_resp in IDLE or RECOVER: ignored; no resp is pulsed.
- A request arriving while the other side is served waits. It is granted at the next IDLE evaluation; the waiting side wins any tie there because last_grant points to the side just served.
- d_read and d_write both high (illegal): treated as a write; pmem_read is forced to 0.

Test Plan:
- Reset mid-SERVE_D with d_write = 1 → pmem_write drops to 0 within the same cycle as rst falling. After release, owner = 00 and the next tie grants D.
- i_read only, i_addr = 0x0000_1000, pmem_resp 5 cycles after pmem_read → pmem_read high from cycle 1. i_resp pulses in the pmem_resp cycle with i_rdata = pmem_rdata. Then one RECOVER cycle (owner = 11), then IDLE.
- i_read and d_write both high in the same cycle after reset → D granted first (pmem_write = 1, pmem_addr = d_addr). I granted after RECOVER+IDLE with pmem_read = 1, pmem_addr = i_addr.
- i_read held high continuously while d_read is re-asserted after each d_resp → grants alternate D, I, D, I; I is never skipped twice in a row.
- Spurious pmem_resp in IDLE → no i_resp or d_resp, state stays IDLE.
- d_read drops in the cycle after grant, pmem_resp arrives 3 cycles later → d_resp still pulses once, then RECOVER, then IDLE. A pending i_read is granted next.

Source files
------------

// File: rtl/fetch_mem_arbiter_if.sv
// Line-port bundle shared by the I-cache, D-cache and the cacheline adaptor.
// master is the arbiter's view; slave is the view of the caches and the adaptor.
interface fetch_mem_arbiter_if #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
);
    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;

    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_addr;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    modport master (
        input  i_read, i_addr,
        output i_rdata, i_resp,
        input  d_read, d_write, d_addr, d_wdata,
        output d_rdata, d_resp,
        output pmem_read, pmem_write, pmem_addr, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport slave (
        output i_read, i_addr,
        input  i_rdata, i_resp,
        output d_read, d_write, d_addr, d_wdata,
        input  d_rdata, d_resp,
        input  pmem_read, pmem_write, pmem_addr, pmem_wdata,
        output pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/fetch_mem_arbiter.sv
// Round-robin arbiter giving the I-side or D-side cache exclusive use of the
// physical-memory line port for one transaction at a time.
module fetch_mem_arbiter #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    fetch_mem_arbiter_if.master bus,
    output logic [1:0]          owner_o
);

    // Encoding doubles as the owner status code.
    localparam logic [1:0] IDLE    = 2'b00;
    localparam logic [1:0] SERVE_I = 2'b01;
    localparam logic [1:0] SERVE_D = 2'b10;
    localparam logic [1:0] RECOVER = 2'b11;

    logic [1:0] state_q, state_d;
    logic       lastGrant_q, lastGrant_d;

    logic              iReq, dReq;
    logic              pmemRead, pmemWrite;
    logic [ADDR_W-1:0] pmemAddr;
    logic [LINE_W-1:0] pmemWdata, iRdata, dRdata;
    logic              iResp, dResp;

    assign iReq = bus.i_read;
    assign dReq = bus.d_read | bus.d_write;

    always_comb begin
        state_d     = state_q;
        lastGrant_d = lastGrant_q;
        case (state_q)
            IDLE: begin
                if (iReq && (!dReq || lastGrant_q)) begin
                    state_d     = SERVE_I;
                    lastGrant_d = 1'b0;
                end else if (dReq) begin
                    state_d     = SERVE_D;
                    lastGrant_d = 1'b1;
                end
            end
            SERVE_I, SERVE_D: begin
                if (bus.pmem_resp) begin
                    state_d = RECOVER;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Commands follow only the owner's request lines; a simultaneous read and
    // write from the D-side is treated as a write.
    always_comb begin
        pmemRead  = 1'b0;
        pmemWrite = 1'b0;
        pmemAddr  = '0;
        pmemWdata = '0;
        iRdata    = '0;
        iResp     = 1'b0;
        dRdata    = '0;
        dResp     = 1'b0;
        case (state_q)
            SERVE_I: begin
                pmemRead = 1'b1;
                pmemAddr = bus.i_addr;
                iRdata   = bus.pmem_rdata;
                iResp    = bus.pmem_resp;
            end
            SERVE_D: begin
                pmemRead  = bus.d_read & ~bus.d_write;
                pmemWrite = bus.d_write;
                pmemAddr  = bus.d_addr;
                pmemWdata = bus.d_wdata;
                dRdata    = bus.pmem_rdata;
                dResp     = bus.pmem_resp;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            lastGrant_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lastGrant_q <= lastGrant_d;
        end
    end

    assign bus.pmem_read  = pmemRead;
    assign bus.pmem_write = pmemWrite;
    assign bus.pmem_addr  = pmemAddr;
    assign bus.pmem_wdata = pmemWdata;
    assign bus.i_rdata    = iRdata;
    assign bus.i_resp     = iResp;
    assign bus.d_rdata    = dRdata;
    assign bus.d_resp     = dResp;
    assign owner_o        = state_q;

endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// Randomised and directed stimulus for fetch_mem_arbiter, compared cycle by
// cycle against a transaction-level model of who owns the memory port.
module tb_fetch_mem_arbiter;

    localparam int LINE_W = 256;
    localparam int ADDR_W = 32;

    logic       clk;
    logic       rst_n;
    logic [1:0] owner;

    fetch_mem_arbiter_if #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) bus ();

    fetch_mem_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .bus     (bus),
        .owner_o (owner)
    );

    int checks = 0;
    int errors = 0;

    // Model: which side holds the port (0 none, 1 I, 2 D), whether the
    // mandatory gap cycle is in progress, and whether D was served last.
    int mServe;
    bit mRecover;
    bit mLastD;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [LINE_W-1:0] randLine();
        logic [LINE_W-1:0] v;
        for (int k = 0; k < LINE_W / 32; k++) begin
            v[k*32 +: 32] = $urandom;
        end
        return v;
    endfunction

    task automatic checkOutput(input string tag, input logic [LINE_W-1:0] observed,
                               input logic [LINE_W-1:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    // One clock cycle: drive at the falling edge, check once settled, then
    // advance the model to what the next rising edge should produce.
    task automatic applyStimulus(input bit rstN, input bit iRd, input bit dRd,
                                 input bit dWr, input bit pResp);
        logic [1:0]        eOwner;
        logic              eRead, eWrite, eIResp, eDResp;
        logic [ADDR_W-1:0] eAddr;
        logic [LINE_W-1:0] eWdata, eIRdata, eDRdata;
        @(negedge clk);
        rst_n          = rstN;
        bus.i_read     = iRd;
        bus.d_read     = dRd;
        bus.d_write    = dWr;
        bus.i_addr     = $urandom;
        bus.d_addr     = $urandom;
        bus.d_wdata    = randLine();
        bus.pmem_rdata = randLine();
        bus.pmem_resp  = pResp;
        #1;
        if (!rstN) begin
            mServe   = 0;
            mRecover = 1'b0;
            mLastD   = 1'b0;
        end

        eOwner  = mRecover ? 2'd3 : 2'(mServe);
        eRead   = 1'b0;
        eWrite  = 1'b0;
        eAddr   = '0;
        eWdata  = '0;
        eIRdata = '0;
        eDRdata = '0;
        eIResp  = 1'b0;
        eDResp  = 1'b0;
        if (!mRecover && mServe == 1) begin
            eRead   = 1'b1;
            eAddr   = bus.i_addr;
            eIRdata = bus.pmem_rdata;
            eIResp  = pResp;
        end else if (!mRecover && mServe == 2) begin
            eWrite  = dWr;
            eRead   = dRd && !dWr;
            eAddr   = bus.d_addr;
            eWdata  = bus.d_wdata;
            eDRdata = bus.pmem_rdata;
            eDResp  = pResp;
        end

        checkOutput("owner",      LINE_W'(owner),          LINE_W'(eOwner));
        checkOutput("pmem_read",  LINE_W'(bus.pmem_read),  LINE_W'(eRead));
        checkOutput("pmem_write", LINE_W'(bus.pmem_write), LINE_W'(eWrite));
        checkOutput("pmem_addr",  LINE_W'(bus.pmem_addr),  LINE_W'(eAddr));
        checkOutput("pmem_wdata", bus.pmem_wdata,          eWdata);
        checkOutput("i_resp",     LINE_W'(bus.i_resp),     LINE_W'(eIResp));
        checkOutput("d_resp",     LINE_W'(bus.d_resp),     LINE_W'(eDResp));
        checkOutput("i_rdata",    bus.i_rdata,             eIRdata);
        checkOutput("d_rdata",    bus.d_rdata,             eDRdata);

        if (rstN) begin
            if (mRecover) begin
                mRecover = 1'b0;
            end else if (mServe != 0) begin
                if (pResp) begin
                    mServe   = 0;
                    mRecover = 1'b1;
                end
            end else begin
                if (iRd && (dRd || dWr)) mServe = mLastD ? 1 : 2;
                else if (iRd)            mServe = 1;
                else if (dRd || dWr)     mServe = 2;
                if (mServe == 1) mLastD = 1'b0;
                if (mServe == 2) mLastD = 1'b1;
            end
        end
    endtask

    initial begin
        int dKind;
        bit iHold;
        rst_n          = 1'b0;
        bus.i_read     = 1'b0;
        bus.i_addr     = '0;
        bus.d_read     = 1'b0;
        bus.d_write    = 1'b0;
        bus.d_addr     = '0;
        bus.d_wdata    = '0;
        bus.pmem_rdata = '0;
        bus.pmem_resp  = 1'b0;
        mServe         = 0;
        mRecover       = 1'b0;
        mLastD         = 1'b0;

        // Reset values, then a lone I-side read answered five cycles later.
        repeat (2) applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        repeat (5) applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 1);
        repeat (3) applyStimulus(1, 0, 0, 0, 0);

        // Spurious adaptor responses while idle.
        repeat (3) applyStimulus(1, 0, 0, 0, 1);

        // Tie straight after reset goes to D, then I after the gap.
        applyStimulus(0, 0, 0, 0, 0);
        for (int k = 0; k < 12; k++) applyStimulus(1, 1, 0, 1, (k % 4) == 3);

        // I held while D re-requests: grants must alternate.
        for (int k = 0; k < 40; k++) applyStimulus(1, 1, 1, 0, (k % 3) == 2);

        // D withdraws its read after the grant; pending I is served next.
        repeat (4) applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 1, 1, 0, 0);
        applyStimulus(1, 1, 1, 0, 0);
        repeat (2) applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 1);
        repeat (4) applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 1);

        // Reset hits in the middle of a D write-back.
        repeat (2) applyStimulus(1, 0, 0, 0, 0);
        repeat (3) applyStimulus(1, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(1, 1, 0, 1, 0);
        applyStimulus(1, 1, 0, 1, 1);

        // Random traffic including illegal D read+write and rare resets.
        iHold = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 3) == 0) iHold = ~iHold;
            dKind = $urandom_range(0, 9);
            applyStimulus($urandom_range(0, 199) != 0, iHold,
                          dKind inside {[1:3], 9}, dKind inside {[4:5], 9},
                          $urandom_range(0, 3) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
